mem_port_master: RTL and testbench

- Load/store initiator that sits between the processor datapath and the single-port data memory.
- Accepts single-word or burst (1-16 word) load/store requests on a valid/ready handshake.
- Sequences addresses and drives the memory's opcode/addr/datain pins, using store opcode 6'b010110.
- Returns read data as a backpressurable stream; signals completion with a done pulse and an error flag.

---
 rtl/mem_port_pkg.sv | 17 +
 rtl/mem_port_if.sv | 44 ++++
 rtl/mem_port_rd_slot.sv | 41 ++++
 rtl/mem_port_master.sv | 147 ++++++++++++++
 tb/tb_mem_port_master.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_pkg.sv
// Shared constants and state encoding for the memory port master.
package mem_port_pkg;

  localparam int LEN_W = 4;

  localparam logic [5:0] OP_STORE = 6'b010110;
  localparam logic [5:0] OP_NOP   = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_port_if.sv
// Request, store-data, load-data and memory pin bundle for the memory port master.
interface mem_port_if #(
  parameter int ADDRESS_WIDTH = 5
);
  import mem_port_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDRESS_WIDTH:0] req_addr;
  logic [LEN_W-1:0]       req_len;

  logic                   wdata_valid;
  logic                   wdata_ready;
  logic [31:0]            wdata;

  logic                   rdata_valid;
  logic                   rdata_ready;
  logic [31:0]            rdata;
  logic                   rdata_last;

  logic                   done;
  logic                   err;

  logic [5:0]             mem_opcode;
  logic [ADDRESS_WIDTH:0] mem_addr;
  logic [31:0]            mem_datain;
  logic [31:0]            mem_dataout;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata, rdata_ready, mem_dataout,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
    output done, err, mem_opcode, mem_addr, mem_datain
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata, rdata_ready, mem_dataout,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
    input  done, err, mem_opcode, mem_addr, mem_datain
  );

endinterface

// File: rtl/mem_port_rd_slot.sv
// One-entry load output register: holds a beat until the consumer takes it.
module mem_port_rd_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [31:0] cap_data_i,
  input  logic        cap_last_i,
  input  logic        rdata_ready_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        rdata_last_o,
  output logic        slot_free_o
);

  logic [31:0] rdata_q;
  logic        valid_q;
  logic        last_q;

  // A new beat may enter in the same cycle the held one leaves.
  assign slot_free_o = !valid_q || rdata_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (capture_i) begin
      rdata_q <= cap_data_i;
      valid_q <= 1'b1;
      last_q  <= cap_last_i;
    end else if (valid_q && rdata_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = valid_q;
  assign rdata_last_o  = last_q;

endmodule

// File: rtl/mem_port_master.sv
// Load/store initiator between the datapath and the single-port data memory.
// state    | meaning
// IDLE     | ready for a request
// WRITE    | issuing store beats as wdata arrives
// READ     | issuing load beats into the output slot
// DRAIN    | waiting for the consumer to take the last load beat
// DONE     | one-cycle done/err pulse
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned SIZE          = 32,
  parameter int          ADDRESS_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  mem_port_if.master bus
);

  localparam int REM_W = LEN_W + 1;

  state_e                 state_q, state_d;
  logic [ADDRESS_WIDTH:0] cur_addr_q, cur_addr_d;
  logic [REM_W-1:0]       remaining_q, remaining_d;
  logic                   err_acc_q, err_acc_d;

  logic                   in_range;
  logic                   capture;
  logic                   cap_last;
  logic                   slot_free;
  logic                   rdata_valid;
  logic [31:0]            cap_data;

  logic                   req_ready;
  logic                   wdata_ready;
  logic                   done;
  logic                   err;
  logic [5:0]             mem_opcode;
  logic [ADDRESS_WIDTH:0] mem_addr;
  logic [31:0]            mem_datain;

  assign in_range = (32'(cur_addr_q) < SIZE);
  assign cap_data = in_range ? bus.mem_dataout : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      err_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      err_acc_q   <= err_acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    err_acc_d   = err_acc_q;
    capture     = 1'b0;
    cap_last    = 1'b0;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_opcode  = OP_NOP;
    mem_addr    = '0;
    mem_datain  = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          cur_addr_d  = bus.req_addr;
          remaining_d = (bus.req_len == '0) ? REM_W'(16) : {1'b0, bus.req_len};
          err_acc_d   = 1'b0;
          state_d     = bus.req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          mem_addr   = cur_addr_q;
          mem_datain = bus.wdata;
          if (in_range) mem_opcode = OP_STORE;
          else          err_acc_d  = 1'b1;
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REM_W'(1)) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        mem_addr = cur_addr_q;
        if (slot_free) begin
          capture  = 1'b1;
          cap_last = (remaining_q == REM_W'(1));
          if (!in_range) err_acc_d = 1'b1;
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REM_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rdata_valid && bus.rdata_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_acc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Nothing may reach the memory or the done port while reset is held.
    if (rst) begin
      mem_opcode = OP_NOP;
      done       = 1'b0;
      err        = 1'b0;
    end
  end

  mem_port_rd_slot u_rd_slot (
    .clk          (clk),
    .rst          (rst),
    .capture_i    (capture),
    .cap_data_i   (cap_data),
    .cap_last_i   (cap_last),
    .rdata_ready_i(bus.rdata_ready),
    .rdata_o      (bus.rdata),
    .rdata_valid_o(rdata_valid),
    .rdata_last_o (bus.rdata_last),
    .slot_free_o  (slot_free)
  );

  assign bus.rdata_valid = rdata_valid;
  assign bus.req_ready   = req_ready;
  assign bus.wdata_ready = wdata_ready;
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.mem_opcode  = mem_opcode;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_datain  = mem_datain;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master: load vector table plus store, stall and reset sequences.
module tb_mem_port_master;
  import mem_port_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_if #(.ADDRESS_WIDTH(5)) bus();

  mem_port_master #(.SIZE(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [31:0] mem [64];
  int          store_cnt;

  function automatic logic [31:0] pre(input int i);
    if (i == 0)      return 32'd310;
    else if (i == 1) return 32'd230;
    else if (i == 2) return 32'd30;
    else if (i == 3) return 32'd50;
    else if (i < 32) return 32'(1000 + i);
    else             return 32'hDEAD;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre(i);
      store_cnt <= 0;
    end else if (bus.mem_opcode == OP_STORE) begin
      mem[bus.mem_addr] <= bus.mem_datain;
      store_cnt <= store_cnt + 1;
    end
  end

  assign bus.mem_dataout = mem[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [31:0] beats_q[$];
  int          last_cnt, last_idx, done_k;
  logic        err_seen;
  logic [31:0] stall_held;

  task automatic run_load(input logic [5:0] a, input logic [3:0] l, input int stall);
    int stall_left;
    bit first_seen;
    stall_left = stall;
    first_seen = 0;
    beats_q.delete();
    last_cnt = 0; last_idx = -1; done_k = -1; err_seen = 1'b0;
    @(negedge clk);
    chk("ld_req_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = l;
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k < 60; k++) begin
      if (bus.done) begin
        done_k = k; err_seen = bus.err;
        break;
      end
      if (bus.rdata_valid && !first_seen) begin
        first_seen = 1;
        stall_held = bus.rdata;
      end
      if (first_seen && stall_left > 0) begin
        bus.rdata_ready = 1'b0;
        stall_left--;
        chk("ld_stall_hold", bus.rdata, stall_held);
        chk("ld_stall_valid", 32'(bus.rdata_valid), 1);
      end else begin
        bus.rdata_ready = 1'b1;
      end
      if (bus.rdata_valid && bus.rdata_ready) begin
        beats_q.push_back(bus.rdata);
        if (bus.rdata_last) begin
          last_cnt++;
          last_idx = beats_q.size();
        end
      end
      @(negedge clk);
    end
    bus.rdata_ready = 1'b1;
    if (done_k < 0) chk("ld_timeout", 0, 1);
  endtask

  task automatic run_store(input logic [5:0] a, input logic [3:0] l,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input int gap);
    logic [31:0] d [3];
    int i, gap_left;
    d[0] = d0; d[1] = d1; d[2] = d2;
    i = 0; gap_left = gap; done_k = -1; err_seen = 1'b0;
    @(negedge clk);
    chk("st_req_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = l;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("st_wdata_ready", 32'(bus.wdata_ready), 1);
    for (int k = 1; k < 40; k++) begin
      if (bus.done) begin
        done_k = k; err_seen = bus.err;
        break;
      end
      if (i < int'(l)) begin
        if (i == 1 && gap_left > 0) begin
          bus.wdata_valid = 1'b0;
          gap_left--;
          #1 chk("st_gap_nop", 32'(bus.mem_opcode), 32'(OP_NOP));
        end else begin
          bus.wdata_valid = 1'b1;
          bus.wdata = d[i];
          if (bus.wdata_ready) i++;
        end
      end else begin
        bus.wdata_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.wdata_valid = 1'b0;
    if (done_k < 0) chk("st_timeout", 0, 1);
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [3:0]  len;
    int          beats;
    logic [31:0] first;
    logic [31:0] last;
    logic        err;
  } vec_t;

  vec_t vt [5];

  initial begin
    int s0;
    logic [5:0] ma;
    logic [31:0] mexp;

    vt[0] = '{6'd0,  4'd4, 4,  32'd310,  32'd50,   1'b0};
    vt[1] = '{6'd2,  4'd3, 3,  32'd30,   32'd1004, 1'b0};
    vt[2] = '{6'd30, 4'd4, 4,  32'd1030, 32'd0,    1'b1};
    vt[3] = '{6'd0,  4'd0, 16, 32'd310,  32'd1015, 1'b0};
    vt[4] = '{6'd63, 4'd2, 2,  32'd0,    32'd310,  1'b1};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.rdata_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready",   32'(bus.req_ready), 1);
    chk("rst_rdata_valid", 32'(bus.rdata_valid), 0);
    chk("rst_done",        32'(bus.done), 0);
    chk("rst_wdata_ready", 32'(bus.wdata_ready), 0);
    chk("rst_mem_addr",    32'(bus.mem_addr), 0);
    chk("rst_rdata",       bus.rdata, 0);

    foreach (vt[v]) begin
      run_load(vt[v].addr, vt[v].len, 0);
      chk("vec_beats", 32'(beats_q.size()), 32'(vt[v].beats));
      if (beats_q.size() == vt[v].beats) begin
        chk("vec_first", beats_q[0], vt[v].first);
        chk("vec_lastdata", beats_q[vt[v].beats-1], vt[v].last);
        for (int j = 0; j < vt[v].beats; j++) begin
          ma = vt[v].addr + 6'(j);
          mexp = (ma < 6'd32) ? pre(int'(ma)) : 32'd0;
          chk("vec_beat_data", beats_q[j], mexp);
        end
      end
      chk("vec_last_cnt", 32'(last_cnt), 1);
      chk("vec_last_pos", 32'(last_idx), 32'(vt[v].beats));
      chk("vec_done_cycle", 32'(done_k), 32'(vt[v].beats + 2));
      chk("vec_err", 32'(err_seen), 32'(vt[v].err));
      @(negedge clk);
      chk("vec_done_pulse", 32'(bus.done), 0);
      chk("vec_idle_ready", 32'(bus.req_ready), 1);
    end

    s0 = store_cnt;
    run_store(6'd5, 4'd2, 32'd11, 32'd22, 32'd0, 1);
    chk("st_count", 32'(store_cnt - s0), 2);
    chk("st_cell5", mem[5], 11);
    chk("st_cell6", mem[6], 22);
    chk("st_done_cycle", 32'(done_k), 4);
    chk("st_err", 32'(err_seen), 0);

    s0 = store_cnt;
    run_store(6'd31, 4'd3, 32'd77, 32'd88, 32'd99, 0);
    chk("st_oor_count", 32'(store_cnt - s0), 1);
    chk("st_oor_cell31", mem[31], 77);
    chk("st_oor_done_cycle", 32'(done_k), 4);
    chk("st_oor_err", 32'(err_seen), 1);

    run_load(6'd0, 4'd3, 4);
    chk("stall_value", stall_held, 310);
    chk("stall_beats", 32'(beats_q.size()), 3);
    if (beats_q.size() == 3) begin
      chk("stall_b0", beats_q[0], 310);
      chk("stall_b1", beats_q[1], 230);
      chk("stall_b2", beats_q[2], 30);
    end
    chk("stall_done_cycle", 32'(done_k), 9);
    chk("stall_err", 32'(err_seen), 0);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 6'd0; bus.req_len = 4'd4;
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_b0", bus.rdata, 310);
    @(negedge clk);
    chk("mid_b1", bus.rdata, 230);
    rst = 1'b1;
    #1 chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_opcode", 32'(bus.mem_opcode), 32'(OP_NOP));
    @(negedge clk);
    rst = 1'b0;
    chk("mid_req_ready",   32'(bus.req_ready), 1);
    chk("mid_rdata_valid", 32'(bus.rdata_valid), 0);
    chk("mid_rdata_last",  32'(bus.rdata_last), 0);
    chk("mid_rdata",       bus.rdata, 0);
    for (int k = 0; k < 4; k++) begin
      chk("mid_no_done", 32'(bus.done), 0);
      @(negedge clk);
    end
    run_load(6'd0, 4'd4, 0);
    chk("post_beats", 32'(beats_q.size()), 4);
    if (beats_q.size() == 4) chk("post_last", beats_q[3], 50);
    chk("post_done_cycle", 32'(done_k), 6);
    chk("post_err", 32'(err_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
